// File: rtl/button_pkg.sv
// Shared constants and channel state type for the pushbutton conditioner.
// Build option: BTN_AUTOREPEAT_EN enables the hold counters and auto-repeat.
package button_pkg;

  localparam int NUM_PB = 4;
  localparam int DB_W   = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/btn_channel.sv
// One debounced button: press/release FSM plus optional hold/repeat counter.
// Build option: BTN_AUTOREPEAT_EN builds the hold counter and repeat pulses.
module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_TICKS     = 10,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 150
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_TICKS);

  ch_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [DB_W-1:0] cnt_inc;
  logic            settle;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;

  // A run of disagreeing ticks starts at 1 from a stable state.
  assign cnt_inc = (state_q == IDLE || state_q == HELD) ?
                   DB_W'(1) : cnt_q + DB_W'(1);
  assign settle  = (cnt_inc == DB_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        IDLE, PRESS_WAIT: begin
          if (!sync_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (settle) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = cnt_inc;
          end
        end
        HELD, REL_WAIT: begin
          if (sync_i) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (settle) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            state_d = REL_WAIT;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] DLY  = HOLD_W'(REPEAT_DELAY_TICKS);
  localparam logic [HOLD_W-1:0] RATE = HOLD_W'(REPEAT_RATE_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] rate_q, rate_d;
  logic              rep_q, rep_d;

  // hold_q stops at the delay; rate_q then paces the repeats.
  always_comb begin
    hold_d = hold_q;
    rate_d = rate_q;
    rep_d  = 1'b0;
    if (!level_q || !level_d) begin
      hold_d = '0;
      rate_d = '0;
    end else if (tick_i) begin
      if (hold_q != DLY) begin
        hold_d = hold_q + HOLD_W'(1);
        rep_d  = (hold_q + HOLD_W'(1) == DLY);
      end else if (rate_q + HOLD_W'(1) == RATE) begin
        rate_d = '0;
        rep_d  = 1'b1;
      end else begin
        rate_d = rate_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      rate_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rate_q <= rate_d;
      rep_q  <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY_TICKS + REPEAT_RATE_TICKS;

  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: synchronizers, shared tick prescaler, channels.
// Build option: BTN_AUTOREPEAT_EN enables auto-repeat on pb_repeat.
module button_conditioner
  import button_pkg::*;
#(
  parameter int TICK_DIV           = 50000,
  parameter int DEBOUNCE_TICKS     = 10,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 150
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release,
  output logic [NUM_PB-1:0] pb_repeat
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [NUM_PB-1:0] sync1_q, sync2_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= pb_raw;
      sync2_q <= sync1_q;
      div_q   <= div_d;
    end
  end

  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .tick_i   (tick),
      .sync_i   (sync2_q[g]),
      .level_o  (pb_level[g]),
      .press_o  (pb_press[g]),
      .release_o(pb_release[g]),
      .repeat_o (pb_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a tick model.
// Expected repeat pulses follow whether BTN_AUTOREPEAT_EN is defined.
module tb_button_conditioner;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int DL = 5;
  localparam int RT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb_raw;
  logic [3:0] pb_level, pb_press, pb_release, pb_repeat;

  button_conditioner #(
    .TICK_DIV          (TD),
    .DEBOUNCE_TICKS    (DB),
    .REPEAT_DELAY_TICKS(DL),
    .REPEAT_RATE_TICKS (RT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_raw    (pb_raw),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_repeat (pb_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] hist[$];
  int n;
  int lvl[4], run[4], held[4];
  logic [3:0] e_lvl, e_prs, e_rel, e_rep;

  int npress[4], nrel[4], nrep[4];
  int fpress[4], rep1[4], rep2[4];

  task automatic clear_stats();
    for (int b = 0; b < 4; b++) begin
      npress[b] = 0; nrel[b] = 0; nrep[b] = 0;
      fpress[b] = -1; rep1[b] = -1; rep2[b] = -1;
    end
  endtask

  // Model: level flips after DB consecutive disagreeing ticks of the
  // input as seen two clocks late; repeats counted in ticks since press.
  task automatic model_edge(input logic r, input logic [3:0] raw);
    logic [3:0] s;
    bit flip;
    e_prs = '0; e_rel = '0; e_rep = '0;
    if (r) begin
      hist.delete();
      n = 0;
      for (int b = 0; b < 4; b++) begin
        lvl[b] = 0; run[b] = 0; held[b] = 0;
      end
      e_lvl = '0;
      return;
    end
    hist.push_back(raw);
    if (hist.size() > 3) void'(hist.pop_front());
    s = (hist.size() == 3) ? hist[0] : 4'b0000;
    if (n % TD == TD - 1) begin
      for (int b = 0; b < 4; b++) begin
        flip = 0;
        if (int'(s[b]) != lvl[b]) begin
          run[b]++;
          if (run[b] == DB) begin
            lvl[b] = 1 - lvl[b];
            run[b] = 0;
            held[b] = 0;
            flip = 1;
            if (lvl[b] == 1) e_prs[b] = 1'b1;
            else e_rel[b] = 1'b1;
          end
        end else begin
          run[b] = 0;
        end
        if (lvl[b] == 1 && !flip) begin
          held[b]++;
`ifdef BTN_AUTOREPEAT_EN
          if (held[b] == DL || (held[b] > DL && (held[b] - DL) % RT == 0))
            e_rep[b] = 1'b1;
`endif
        end
      end
    end
    n++;
    for (int b = 0; b < 4; b++) e_lvl[b] = (lvl[b] == 1);
  endtask

  task automatic step(input logic r, input logic [3:0] raw);
    rst = r;
    pb_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    cyc++;
    checks++;
    assert (pb_level === e_lvl) else begin
      errors++;
      $error("FAIL level cyc=%0d got=%b exp=%b", cyc, pb_level, e_lvl);
    end
    checks++;
    assert (pb_press === e_prs) else begin
      errors++;
      $error("FAIL press cyc=%0d got=%b exp=%b", cyc, pb_press, e_prs);
    end
    checks++;
    assert (pb_release === e_rel) else begin
      errors++;
      $error("FAIL release cyc=%0d got=%b exp=%b", cyc, pb_release, e_rel);
    end
    checks++;
    assert (pb_repeat === e_rep) else begin
      errors++;
      $error("FAIL repeat cyc=%0d got=%b exp=%b", cyc, pb_repeat, e_rep);
    end
    checks++;
    assert ((pb_press & pb_repeat) === 4'b0000) else begin
      errors++;
      $error("FAIL press_and_repeat cyc=%0d got=%b exp=0000", cyc,
             pb_press & pb_repeat);
    end
    for (int b = 0; b < 4; b++) begin
      if (pb_press[b] === 1'b1) begin
        npress[b]++;
        if (fpress[b] < 0) fpress[b] = cyc;
      end
      if (pb_release[b] === 1'b1) nrel[b]++;
      if (pb_repeat[b] === 1'b1) begin
        nrep[b]++;
        if (rep1[b] < 0) rep1[b] = cyc;
        else if (rep2[b] < 0) rep2[b] = cyc;
      end
    end
  endtask

  initial begin
    int t0;
    logic [3:0] rr;
    int left[4];

    rst = 1'b1;
    pb_raw = '0;
    clear_stats();
    repeat (3) step(1'b1, 4'b0000);

    // Clean press on button 0.
    repeat (9) step(1'b0, 4'b0000);
    clear_stats();
    step(1'b0, 4'b0001);
    t0 = cyc;
    repeat (24) step(1'b0, 4'b0001);
    checks++;
    assert (npress[0] == 1 && fpress[0] - t0 >= 10 && fpress[0] - t0 <= 15)
    else begin
      errors++;
      $error("FAIL clean_press count=%0d lat=%0d exp=1 in 10..15",
             npress[0], fpress[0] - t0);
    end
    checks++;
    assert (npress[1] + npress[2] + npress[3] + nrel[0] == 0) else begin
      errors++;
      $error("FAIL clean_others got=%0d exp=0",
             npress[1] + npress[2] + npress[3] + nrel[0]);
    end
    repeat (20) step(1'b0, 4'b0000);

    // Bouncing button 1.
    clear_stats();
    for (int i = 0; i < 40; i++)
      step(1'b0, ((i / 3) % 2 == 1) ? 4'b0010 : 4'b0000);
    repeat (20) step(1'b0, 4'b0000);
    checks++;
    assert (npress[1] + nrel[1] + nrep[1] == 0) else begin
      errors++;
      $error("FAIL bounce pulses got=%0d exp=0", npress[1] + nrel[1] + nrep[1]);
    end

    // Hold and repeat on button 2.
    clear_stats();
    repeat (80) step(1'b0, 4'b0100);
    repeat (30) step(1'b0, 4'b0000);
    checks++;
    assert (npress[2] == 1 && nrel[2] == 1) else begin
      errors++;
      $error("FAIL hold_press_rel got=%0d/%0d exp=1/1", npress[2], nrel[2]);
    end
`ifdef BTN_AUTOREPEAT_EN
    checks++;
    assert (rep1[2] - fpress[2] == 20) else begin
      errors++;
      $error("FAIL first_repeat gap got=%0d exp=20", rep1[2] - fpress[2]);
    end
    checks++;
    assert (rep2[2] - rep1[2] == 8) else begin
      errors++;
      $error("FAIL repeat_rate gap got=%0d exp=8", rep2[2] - rep1[2]);
    end
`else
    checks++;
    assert (nrep[0] + nrep[1] + nrep[2] + nrep[3] == 0) else begin
      errors++;
      $error("FAIL repeat_off got=%0d exp=0",
             nrep[0] + nrep[1] + nrep[2] + nrep[3]);
    end
`endif

    // Simultaneous press on buttons 0 and 3.
    clear_stats();
    repeat (21) step(1'b0, 4'b1001);
    checks++;
    assert (npress[0] == 1 && npress[3] == 1 && fpress[0] == fpress[3]) else begin
      errors++;
      $error("FAIL simultaneous got=%0d@%0d %0d@%0d exp=same cycle",
             npress[0], fpress[0], npress[3], fpress[3]);
    end

    // Reset while button 3 is held.
    step(1'b1, 4'b1001);
    checks++;
    assert ({pb_level, pb_press, pb_release, pb_repeat} === 16'h0000) else begin
      errors++;
      $error("FAIL reset_outputs got=%h exp=0000",
             {pb_level, pb_press, pb_release, pb_repeat});
    end
    clear_stats();
    repeat (25) step(1'b0, 4'b1001);
    checks++;
    assert (npress[3] == 1) else begin
      errors++;
      $error("FAIL repress_after_reset got=%0d exp=1", npress[3]);
    end
    repeat (20) step(1'b0, 4'b0000);

    // Randomized hold lengths and occasional reset.
    rr = '0;
    for (int b = 0; b < 4; b++) left[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (left[b] == 0) begin
          rr[b] = ($urandom_range(0, 1) == 1);
          left[b] = (i % 500 < 250) ? $urandom_range(1, 12)
                                    : $urandom_range(5, 60);
        end else begin
          left[b]--;
        end
      end
      step($urandom_range(0, 399) == 0, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
